// File: rtl/rf_bypass_sb.sv
// rf_bypass_sb: multi-read-port register file with write-to-read
// bypass and per-register pending-write scoreboard for RAW stalls.
module rf_bypass_sb #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = 3,
  parameter int NUM_RD   = 2,
  parameter int PEND_W   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*SEL_W-1:0]    rd_sel,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr_en,
  input  logic [SEL_W-1:0]           wr_sel,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       issue_en,
  input  logic [SEL_W-1:0]           issue_sel,
  input  logic                       flush,
  output logic                       err
);

  localparam logic [PEND_W-1:0] PMAX = '1;
  localparam logic [PEND_W-1:0] PONE = PEND_W'(1);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [PEND_W-1:0]   r_pend [NUM_REGS];
  logic                r_err;

  logic [NUM_REGS-1:0] w_inc;
  logic [NUM_REGS-1:0] w_dec;
  logic                w_ovf;

  // Per-register scoreboard events; a flush discards the issue.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    w_ovf = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_inc[r] = issue_en && !flush
              && (issue_sel == SEL_W'(r));
      w_dec[r] = wr_en && (wr_sel == SEL_W'(r))
              && (r_pend[r] != '0);
      w_ovf = w_ovf | (w_inc[r] && !w_dec[r]
              && (r_pend[r] == PMAX));
    end
  end

  // Architectural register storage with writeback port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++)
        r_regs[r] <= '0;
    end else if (wr_en) begin
      r_regs[wr_sel] <= wr_data;
    end
  end

  // Pending counters: saturate at max, flush clears all.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      for (int r = 0; r < NUM_REGS; r++)
        r_pend[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (w_inc[r] && !w_dec[r]
            && r_pend[r] != PMAX)
          r_pend[r] <= r_pend[r] + PONE;
        else if (w_dec[r] && !w_inc[r])
          r_pend[r] <= r_pend[r] - PONE;
      end
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst)
      r_err <= 1'b0;
    else if (w_ovf)
      r_err <= 1'b1;
  end

  assign err = r_err;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [SEL_W-1:0]  w_sel;
    logic              w_hit;
    logic [PEND_W-1:0] w_cnt;

    assign w_sel = rd_sel[g*SEL_W +: SEL_W];
    assign w_hit = wr_en && (wr_sel == w_sel);
    assign w_cnt = r_pend[w_sel];

    assign rd_data[g*DATA_W +: DATA_W] =
      w_hit ? wr_data : r_regs[w_sel];

    // The last outstanding write landing now is bypassed.
    assign rd_busy[g] = (w_cnt > PONE)
      || (w_cnt == PONE && !w_hit);
  end

endmodule

// File: tb/tb_rf_bypass_sb.sv
// tb_rf_bypass_sb: drives a 2-port 16-bit and a 3-port 32-bit
// instance from one stream, checked against a behavioural model.
module tb_rf_bypass_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  s0, s1, s2;
  logic        wr_en;
  logic [2:0]  wr_sel;
  logic [31:0] wr_data;
  logic        issue_en;
  logic [2:0]  issue_sel;
  logic        flush;

  logic [31:0] rda_data;
  logic [1:0]  rda_busy;
  logic        a_err;
  logic [95:0] rdb_data;
  logic [2:0]  rdb_busy;
  logic        b_err;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  rf_bypass_sb u_a (
    .clk(clk), .rst(rst),
    .rd_sel({s1, s0}),
    .rd_data(rda_data), .rd_busy(rda_busy),
    .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_data(wr_data[15:0]),
    .issue_en(issue_en), .issue_sel(issue_sel),
    .flush(flush), .err(a_err)
  );

  rf_bypass_sb #(.DATA_W(32), .NUM_RD(3)) u_b (
    .clk(clk), .rst(rst),
    .rd_sel({s2, s1, s0}),
    .rd_data(rdb_data), .rd_busy(rdb_busy),
    .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_data(wr_data),
    .issue_en(issue_en), .issue_sel(issue_sel),
    .flush(flush), .err(b_err)
  );

  // Behavioural model: plain integer counters per register.
  logic [31:0] m_regs [8];
  int          m_pend [8];
  bit          m_err;

  function automatic int next_pend(int r);
    bit inc;
    bit dec;
    int p;
    p = m_pend[r];
    if (flush) return 0;
    inc = issue_en && (issue_sel == r);
    dec = wr_en && (wr_sel == r) && (p > 0);
    if (inc && !dec) return (p == 3) ? 3 : p + 1;
    if (dec && !inc) return p - 1;
    return p;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < 8; r++) begin
        m_regs[r] <= '0;
        m_pend[r] <= 0;
      end
      m_err <= 1'b0;
    end else begin
      if (wr_en) m_regs[wr_sel] <= wr_data;
      for (int r = 0; r < 8; r++)
        m_pend[r] <= next_pend(r);
      if (!flush && issue_en && m_pend[issue_sel] == 3
          && !(wr_en && wr_sel == issue_sel))
        m_err <= 1'b1;
    end
  end

  function automatic logic [31:0] exp_data(logic [2:0] s);
    if (wr_en && wr_sel == s) return wr_data;
    return m_regs[s];
  endfunction

  function automatic logic exp_busy(logic [2:0] s);
    if (m_pend[s] > 1) return 1'b1;
    return (m_pend[s] == 1) && !(wr_en && wr_sel == s);
  endfunction

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h",
               nm, $time, act, exp);
    end
  endtask

  function automatic logic [2:0] sel_of(int i);
    return (i == 0) ? s0 : (i == 1) ? s1 : s2;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check("b_data", rdb_data[i*32 +: 32],
              exp_data(sel_of(i)));
        check("b_busy", {31'd0, rdb_busy[i]},
              {31'd0, exp_busy(sel_of(i))});
        if (i < 2) begin
          check("a_data", {16'd0, rda_data[i*16 +: 16]},
                {16'd0, exp_data(sel_of(i)) & 32'hFFFF});
          check("a_busy", {31'd0, rda_busy[i]},
                {31'd0, exp_busy(sel_of(i))});
        end
      end
      check("a_err", {31'd0, a_err}, {31'd0, m_err});
      check("b_err", {31'd0, b_err}, {31'd0, m_err});
    end
  end

  task automatic idle();
    wr_en = 1'b0;
    issue_en = 1'b0;
    flush = 1'b0;
  endtask

  task automatic half();
    @(negedge clk);
    #1;
  endtask

  task automatic fin();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(string nm, logic [31:0] act,
                     logic [31:0] exp);
    check(nm, act, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle();
    wr_sel = '0; wr_data = '0; issue_sel = '0;
    s0 = 3'd0; s1 = 3'd3; s2 = 3'd7;
    fin(); fin();
    rst = 1'b1;
    chk_en = 1'b1;

    // reset state
    half();
    pin("rst_b_data", rdb_data[31:0] | rdb_data[63:32]
        | rdb_data[95:64], 32'd0);
    pin("rst_busy", {29'd0, rdb_busy}, 32'd0);
    pin("rst_err", {30'd0, a_err, b_err}, 32'd0);
    fin();

    // write with same-cycle bypass, then stored value
    wr_en = 1'b1; wr_sel = 3'd3; wr_data = 32'hBEEF;
    s0 = 3'd3;
    half();
    pin("byp_a", {16'd0, rda_data[15:0]}, 32'hBEEF);
    pin("byp_b", rdb_data[31:0], 32'hBEEF);
    fin();
    idle();
    half();
    pin("store_a", {16'd0, rda_data[15:0]}, 32'hBEEF);
    fin();

    // single issue then writeback
    issue_en = 1'b1; issue_sel = 3'd5; s1 = 3'd5;
    half();
    pin("iss_same_cyc", {31'd0, rda_busy[1]}, 32'd0);
    fin();
    idle();
    half();
    pin("iss_busy", {31'd0, rda_busy[1]}, 32'd1);
    fin();
    wr_en = 1'b1; wr_sel = 3'd5; wr_data = 32'h0012;
    half();
    pin("wb_busy", {31'd0, rda_busy[1]}, 32'd0);
    pin("wb_data", {16'd0, rda_data[31:16]}, 32'h0012);
    fin();
    idle();
    half();
    pin("wb_after", {31'd0, rda_busy[1]}, 32'd0);
    fin();

    // three issues to r2, fourth overflows
    s0 = 3'd2;
    issue_en = 1'b1; issue_sel = 3'd2;
    fin(); fin(); fin();
    idle();
    half();
    pin("ovf_busy", {31'd0, rda_busy[0]}, 32'd1);
    pin("ovf_err0", {31'd0, a_err}, 32'd0);
    fin();
    issue_en = 1'b1;
    fin();
    idle();
    half();
    pin("ovf_err1", {30'd0, a_err, b_err}, 32'd3);
    fin(); fin();
    half();
    pin("ovf_sticky", {31'd0, b_err}, 32'd1);
    fin();
    wr_en = 1'b1; wr_sel = 3'd2; wr_data = 32'h1;
    fin();
    wr_data = 32'h2;
    fin();
    idle();
    half();
    pin("drain_busy", {31'd0, rda_busy[0]}, 32'd1);
    fin();
    wr_en = 1'b1; wr_data = 32'h3;
    half();
    pin("drain_last", {31'd0, rda_busy[0]}, 32'd0);
    fin();
    idle();
    half();
    pin("drain_data", rdb_data[31:0], 32'h3);
    pin("drain_done", {31'd0, rdb_busy[0]}, 32'd0);
    fin();

    // simultaneous issue and writeback on r1
    s1 = 3'd1;
    issue_en = 1'b1; issue_sel = 3'd1;
    fin();
    wr_en = 1'b1; wr_sel = 3'd1; wr_data = 32'h7;
    half();
    pin("sim_same", {31'd0, rda_busy[1]}, 32'd0);
    fin();
    idle();
    half();
    pin("sim_next", {31'd0, rda_busy[1]}, 32'd1);
    fin();
    flush = 1'b1; issue_en = 1'b1; issue_sel = 3'd4;
    s0 = 3'd4;
    fin();
    idle();
    half();
    pin("flush_busy", {29'd0, rdb_busy}, 32'd0);
    pin("flush_err", {31'd0, a_err}, 32'd1);
    fin();

    // mixed traffic, checked by the model every cycle
    for (int k = 0; k < 40; k++) begin
      wr_en = 1'($urandom_range(0, 1));
      wr_sel = 3'($urandom_range(0, 7));
      wr_data = $urandom;
      issue_en = 1'($urandom_range(0, 1));
      issue_sel = 3'($urandom_range(0, 7));
      flush = ($urandom_range(0, 7) == 0);
      s0 = 3'($urandom_range(0, 7));
      s1 = 3'($urandom_range(0, 7));
      s2 = 3'($urandom_range(0, 7));
      fin();
    end
    idle();

    // three ports on 0,0,7 with write to 7
    wr_en = 1'b1; wr_sel = 3'd0; wr_data = 32'h1111_2222;
    fin();
    s0 = 3'd0; s1 = 3'd0; s2 = 3'd7;
    wr_sel = 3'd7; wr_data = 32'hCAFE_F00D;
    half();
    pin("mp_p0", rdb_data[31:0], 32'h1111_2222);
    pin("mp_p1", rdb_data[63:32], 32'h1111_2222);
    pin("mp_p2", rdb_data[95:64], 32'hCAFE_F00D);
    pin("mp_a1", {16'd0, rda_data[31:16]}, 32'h2222);
    fin();
    issue_en = 1'b1; issue_sel = 3'd7;
    wr_sel = 3'd3; wr_data = 32'h55;
    fin();
    rst = 1'b0;
    fin();
    rst = 1'b1;
    idle();
    s0 = 3'd0; s1 = 3'd3; s2 = 3'd7;
    half();
    pin("mid_rst_data", rdb_data[31:0] | rdb_data[63:32]
        | rdb_data[95:64], 32'd0);
    pin("mid_rst_busy", {29'd0, rdb_busy}, 32'd0);
    pin("mid_rst_err", {30'd0, a_err, b_err}, 32'd0);
    fin();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
